// File: rtl/count_enable_gen.sv
// count_enable_gen: push-button front end for the 8-bit Counter.
// Synchronises the raw Button, debounces it into Pressed and emits one
// registered one-cycle Enable pulse per accepted press.
// Optional feature macro: AUTO_REPEAT_EN (held button auto-repeats Enable).
module count_enable_gen #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_PERIOD   = 16
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Button,
    output logic Enable,
    output logic Pressed
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 2 || REPEAT_DELAY < 1) begin : g_param_check
        $error("count_enable_gen: illegal parameter value");
    end

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TMR_W   = $clog2(RPT_MAX);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nxt;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1
    } state_t;
`endif

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   rise_evt;
    logic                   fall_evt;
    state_t                 state;
    state_t                 state_nxt;
    logic                   enable_nxt;

    assign sync_q = sync_ff[SYNC_STAGES-1];

    // Accept/clear events are decoded from the debounce state so the FSM
    // reacts on the very edge where Pressed changes.
    assign rise_evt = (sync_q != Pressed) && (cnt == CNT_MAX) && sync_q;
    assign fall_evt = (sync_q != Pressed) && (cnt == CNT_MAX) && !sync_q;

    // Button synchroniser chain.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], Button};
        end
    end

    // Debounce: Pressed follows sync_q after DEBOUNCE_CYCLES stable mismatching edges.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt     <= '0;
            Pressed <= 1'b0;
        end else if (sync_q == Pressed) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            Pressed <= sync_q;
            cnt     <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // FSM state, repeat timer and registered Enable.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            Enable <= 1'b0;
`ifdef AUTO_REPEAT_EN
            tmr    <= '0;
`endif
        end else begin
            state  <= state_nxt;
            Enable <= enable_nxt;
`ifdef AUTO_REPEAT_EN
            tmr    <= tmr_nxt;
`endif
        end
    end

    // Next-state and pulse decode; release always wins over a due repeat pulse.
    always_comb begin
        state_nxt  = state;
        enable_nxt = 1'b0;
`ifdef AUTO_REPEAT_EN
        tmr_nxt    = tmr;
`endif
        case (state)
            IDLE: begin
                if (rise_evt) begin
                    state_nxt  = HELD;
                    enable_nxt = 1'b1;
`ifdef AUTO_REPEAT_EN
                    tmr_nxt    = '0;
`endif
                end
            end
            HELD: begin
                if (fall_evt) begin
                    state_nxt = IDLE;
`ifdef AUTO_REPEAT_EN
                    tmr_nxt   = '0;
                end else if (tmr == DELAY_LAST) begin
                    state_nxt  = REPEAT;
                    enable_nxt = 1'b1;
                    tmr_nxt    = '0;
                end else begin
                    tmr_nxt = tmr + 1'b1;
`endif
                end
            end
`ifdef AUTO_REPEAT_EN
            REPEAT: begin
                if (fall_evt) begin
                    state_nxt = IDLE;
                    tmr_nxt   = '0;
                end else if (tmr == PERIOD_LAST) begin
                    enable_nxt = 1'b1;
                    tmr_nxt    = '0;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
